// File: rtl/game_area_pkg.sv
// Shared types and defaults for the game-area row memory arbiter.
package game_area_pkg;

    localparam int          ROWS_DEF       = 20;
    localparam int          COLS_DEF       = 12;
    localparam logic [11:0] EMPTY_ROW_DEF  = 12'h801;
    localparam int          STARVE_MAX_DEF = 16;
    localparam int          AW             = 5;

    localparam logic [1:0] OP_CLEAR_ALL = 2'b01;
    localparam logic [1:0] OP_COLLAPSE  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SH_RD,
        ST_SH_CAP,
        ST_SH_WR,
        ST_SH_TOP,
        ST_DONE
    } seq_state_t;

    // Row address is inside the stored playfield (works up to 32 rows).
    function automatic logic row_ok(input logic [AW-1:0] a, input int rows);
        return ({1'b0, a} < rows[AW:0]);
    endfunction

endpackage

// File: rtl/game_area_ram.sv
// Single-port row memory: synchronous write, registered read (read data
// holds across writes and idle cycles).
module game_area_ram #(
    parameter int ROWS = 20,
    parameter int COLS = 12
) (
    input  logic            clk,
    input  logic            i_en,
    input  logic            i_we,
    input  logic [4:0]      i_addr,
    input  logic [COLS-1:0] i_wdata,
    output logic [COLS-1:0] o_rdata
);

    logic [COLS-1:0] r_mem [ROWS];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/game_area_arbiter.sv
// Arbitrates the game-area row RAM between video, the clear/collapse sequencer
// and game logic. GAME_AREA_STARVE_GUARD_EN enables the starvation guard.
module game_area_arbiter
    import game_area_pkg::*;
#(
    parameter int              ROWS       = ROWS_DEF,
    parameter int              COLS       = COLS_DEF,
    parameter logic [COLS-1:0] EMPTY_ROW  = EMPTY_ROW_DEF,
    parameter int              STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vid_req,
    input  logic [AW-1:0]   vid_addr,
    output logic [COLS-1:0] vid_data,
    output logic            vid_miss,
    input  logic            lg_req,
    input  logic            lg_we,
    input  logic [AW-1:0]   lg_addr,
    input  logic [COLS-1:0] lg_wdata,
    output logic            lg_gnt,
    output logic            lg_rvalid,
    output logic [COLS-1:0] lg_rdata,
    input  logic            cmd_valid,
    input  logic [1:0]      cmd_op,
    input  logic [AW-1:0]   cmd_row,
    output logic            cmd_ready,
    output logic            busy,
    output logic            done,
    output logic            cmd_err
);

    seq_state_t      r_state;
    logic [AW-1:0]   r_idx;
    logic [COLS-1:0] r_hold;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            r_vid_p1;
    logic            r_vid_ok_p1;
    logic            r_miss_p1;
    logic            r_lg_p1;
    logic            r_lg_ok_p1;

    logic            w_seq_req;
    logic            w_lg_req;
    logic            w_steal;
    logic            w_vid_go;
    logic            w_seq_go;
    logic            w_lg_go;
    logic            w_ram_en;
    logic            w_ram_we;
    logic [AW-1:0]   w_ram_addr;
    logic [COLS-1:0] w_ram_wdata;
    logic [COLS-1:0] w_ram_rdata;

    assign w_seq_req = (r_state == ST_CLR) || (r_state == ST_SH_RD) ||
                       (r_state == ST_SH_WR) || (r_state == ST_SH_TOP);
    assign w_lg_req  = lg_req && !r_busy;
    assign w_vid_go  = vid_req && !w_steal;
    assign w_seq_go  = w_seq_req && !w_vid_go;
    assign w_lg_go   = w_lg_req && !w_vid_go && !w_seq_req;

    assign lg_gnt    = w_lg_go;
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = r_busy;
    assign done      = r_done;
    assign cmd_err   = r_err;

`ifdef GAME_AREA_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_MAX + 1);

    logic [WAIT_W-1:0] r_wait;
    logic              w_pend;

    assign w_pend  = w_seq_req || w_lg_req;
    assign w_steal = w_pend && (r_wait >= WAIT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (!w_pend || w_seq_go || w_lg_go) begin
            r_wait <= '0;
        end else if (r_wait < WAIT_W'(STARVE_MAX)) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end
`else
    assign w_steal = 1'b0;
`endif

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = vid_addr;
        w_ram_wdata = r_hold;
        if (w_vid_go) begin
            w_ram_en   = row_ok(vid_addr, ROWS);
            w_ram_addr = vid_addr;
        end else if (w_seq_go) begin
            w_ram_en = 1'b1;
            case (r_state)
                ST_CLR: begin
                    w_ram_we    = 1'b1;
                    w_ram_addr  = r_idx;
                    w_ram_wdata = EMPTY_ROW;
                end
                ST_SH_RD: begin
                    w_ram_addr = r_idx - AW'(1);
                end
                ST_SH_WR: begin
                    w_ram_we    = 1'b1;
                    w_ram_addr  = r_idx;
                    w_ram_wdata = r_hold;
                end
                ST_SH_TOP: begin
                    w_ram_we    = 1'b1;
                    w_ram_addr  = '0;
                    w_ram_wdata = EMPTY_ROW;
                end
                default: w_ram_en = 1'b0;
            endcase
        end else if (w_lg_go) begin
            // Out-of-range logic accesses are granted but never touch the RAM.
            w_ram_en    = row_ok(lg_addr, ROWS);
            w_ram_we    = lg_we;
            w_ram_addr  = lg_addr;
            w_ram_wdata = lg_wdata;
        end
    end

    game_area_ram #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_busy <= 1'b1;
                        if (cmd_op == OP_CLEAR_ALL) begin
                            r_idx   <= '0;
                            r_state <= ST_CLR;
                        end else if (cmd_op == OP_COLLAPSE) begin
                            if (!row_ok(cmd_row, ROWS)) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                            end else if (cmd_row == '0) begin
                                r_state <= ST_SH_TOP;
                            end else begin
                                r_idx   <= cmd_row;
                                r_state <= ST_SH_RD;
                            end
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_CLR: begin
                    if (w_seq_go) begin
                        if (r_idx == AW'(ROWS - 1)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                ST_SH_RD: begin
                    if (w_seq_go) r_state <= ST_SH_CAP;
                end
                ST_SH_CAP: begin
                    r_hold  <= w_ram_rdata;
                    r_state <= ST_SH_WR;
                end
                ST_SH_WR: begin
                    if (w_seq_go) begin
                        if (r_idx == AW'(1)) begin
                            r_state <= ST_SH_TOP;
                        end else begin
                            r_idx   <= r_idx - AW'(1);
                            r_state <= ST_SH_RD;
                        end
                    end
                end
                ST_SH_TOP: begin
                    if (w_seq_go) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Second read-latency stage; a stolen video slot repeats the last row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vid_p1    <= 1'b0;
            r_vid_ok_p1 <= 1'b0;
            r_miss_p1   <= 1'b0;
            r_lg_p1     <= 1'b0;
            r_lg_ok_p1  <= 1'b0;
            vid_data    <= '0;
            vid_miss    <= 1'b0;
            lg_rvalid   <= 1'b0;
            lg_rdata    <= '0;
        end else begin
            r_vid_p1    <= w_vid_go;
            r_vid_ok_p1 <= row_ok(vid_addr, ROWS);
            r_miss_p1   <= vid_req && w_steal;
            r_lg_p1     <= w_lg_go && !lg_we;
            r_lg_ok_p1  <= row_ok(lg_addr, ROWS);
            vid_miss    <= r_miss_p1;
            lg_rvalid   <= r_lg_p1;
            if (r_vid_p1) vid_data <= r_vid_ok_p1 ? w_ram_rdata : EMPTY_ROW;
            if (r_lg_p1)  lg_rdata <= r_lg_ok_p1 ? w_ram_rdata : EMPTY_ROW;
        end
    end

endmodule

// File: tb/tb_game_area_arbiter.sv
// Scoreboard bench for game_area_arbiter: directed vectors push expected
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_game_area_arbiter;
    import game_area_pkg::*;

    localparam int          ROWS  = 20;
    localparam int          COLS  = 12;
    localparam logic [11:0] EMPTY = 12'h801;
`ifdef GAME_AREA_STARVE_GUARD_EN
    localparam int STARVE_GNT = 16;
`else
    localparam int STARVE_GNT = 24;
`endif

    logic            clk;
    logic            rst;
    logic            vid_req;
    logic [4:0]      vid_addr;
    logic [COLS-1:0] vid_data;
    logic            vid_miss;
    logic            lg_req;
    logic            lg_we;
    logic [4:0]      lg_addr;
    logic [COLS-1:0] lg_wdata;
    logic            lg_gnt;
    logic            lg_rvalid;
    logic [COLS-1:0] lg_rdata;
    logic            cmd_valid;
    logic [1:0]      cmd_op;
    logic [4:0]      cmd_row;
    logic            cmd_ready;
    logic            busy;
    logic            done;
    logic            cmd_err;

    game_area_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_miss  (vid_miss),
        .lg_req    (lg_req),
        .lg_we     (lg_we),
        .lg_addr   (lg_addr),
        .lg_wdata  (lg_wdata),
        .lg_gnt    (lg_gnt),
        .lg_rvalid (lg_rvalid),
        .lg_rdata  (lg_rdata),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] d;
        bit          miss;
        int          due;
    } dexp_t;

    typedef struct {
        bit err;
        int due;
    } cexp_t;

    dexp_t       q_vid[$];
    dexp_t       q_lg[$];
    cexp_t       q_done[$];
    dexp_t       mv;
    cexp_t       mc;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] model [ROWS];
    logic [11:0] old   [ROWS];
    logic [11:0] last_vid = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event state wrong at cycle %0d (got event/none, expected opposite)", name, cyc);
    endtask

    function automatic logic [11:0] exp_row(input logic [4:0] a);
        return (a < ROWS) ? model[a] : EMPTY;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (lg_rvalid) begin
                if (q_lg.size() == 0) fail("lg_rvalid_unexpected");
                else begin
                    mv = q_lg.pop_front();
                    chk("lg_rdata", lg_rdata, mv.d);
                    chk("lg_latency", cyc, mv.due);
                end
            end else if (q_lg.size() != 0 && q_lg[0].due < cyc) begin
                void'(q_lg.pop_front());
                fail("lg_rvalid_missing");
            end

            if (q_vid.size() != 0 && q_vid[0].due <= cyc) begin
                mv = q_vid.pop_front();
                if (mv.due != cyc) fail("vid_slot_missing");
                else begin
                    chk("vid_data", vid_data, mv.d);
                    chk("vid_miss", vid_miss, mv.miss);
                end
            end else if (vid_miss) begin
                fail("vid_miss_unexpected");
            end

            if (done) begin
                if (q_done.size() == 0) fail("done_unexpected");
                else begin
                    mc = q_done.pop_front();
                    chk("cmd_err", cmd_err, mc.err);
                    chk("done_latency", cyc, mc.due);
                end
            end else if (q_done.size() != 0 && q_done[0].due < cyc) begin
                void'(q_done.pop_front());
                fail("done_missing");
            end
        end
    end

    task automatic vid_drive(input logic [4:0] a, input logic [11:0] e, input bit m);
        vid_req  = 1'b1;
        vid_addr = a;
        q_vid.push_back('{e, m, cyc + 2});
        last_vid = e;
    endtask

    task automatic lg_op(input bit we, input logic [4:0] a, input logic [11:0] d, output int gcyc);
        lg_req   = 1'b1;
        lg_we    = we;
        lg_addr  = a;
        lg_wdata = d;
        gcyc     = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (lg_gnt) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) fail("lg_grant_timeout");
        else if (we) begin
            if (a < ROWS) model[a] = d;
        end else begin
            q_lg.push_back('{exp_row(a), 1'b0, gcyc + 2});
        end
        @(posedge clk);
        #1;
        lg_req = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] row, input int lat, input bit err);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        q_done.push_back('{err, cyc + lat});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (q_done.size() == 0) break;
        end
        if (q_done.size() != 0) begin
            fail("done_timeout");
            q_done.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int          g;
    int          s;
    int          s2;
    logic [4:0]  va;

    initial begin
        rst = 1'b1; vid_req = 0; vid_addr = 0; lg_req = 0; lg_we = 0; lg_addr = 0;
        lg_wdata = 0; cmd_valid = 0; cmd_op = 0; cmd_row = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_vid_miss", vid_miss, 0);
        chk("rst_lg_gnt", lg_gnt, 0);
        chk("rst_lg_rvalid", lg_rvalid, 0);
        chk("rst_lg_rdata", lg_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;

        // Logic write/read and out-of-range accesses
        lg_op(1, 5, 12'hFFF, g);
        lg_op(0, 5, 0, g);
        lg_op(1, 25, 12'h123, g);
        lg_op(0, 25, 0, g);

        for (int i = 0; i < ROWS; i++) lg_op(1, 5'(i), 12'(i), g);

        // Continuous video sweep including an out-of-range row
        for (int i = 0; i <= ROWS; i++) begin
            va = (i < ROWS) ? 5'(i) : 5'd28;
            vid_drive(va, exp_row(va), 1'b0);
            @(posedge clk);
            #1;
        end
        vid_req = 1'b0;

        // Logic starved by continuous video
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    va = 5'(2 + (k % 2));
`ifdef GAME_AREA_STARVE_GUARD_EN
                    if (k == 16) vid_drive(va, last_vid, 1'b1);
                    else
`endif
                    vid_drive(va, exp_row(va), 1'b0);
                    @(posedge clk);
                    #1;
                end
                vid_req = 1'b0;
            end
            begin
                s = cyc;
                lg_op(0, 5, 0, g);
                chk("starve_grant_cycle", g, s + STARVE_GNT);
            end
        join

        // COLLAPSE 3 with a logic request held off while busy
        for (int i = 3; i >= 1; i--) model[i] = model[i - 1];
        model[0] = EMPTY;
        fork
            begin
                issue(OP_COLLAPSE, 3, 11, 1'b0);
                wait_done();
            end
            begin
                @(posedge clk);
                #1;
                s2 = cyc;
                lg_op(0, 4, 0, g);
                chk("busy_grant_cycle", g, s2 + 11);
            end
        join
        for (int i = 0; i <= 5; i++) lg_op(0, 5'(i), 0, g);

        // COLLAPSE 0 only rewrites row 0
        lg_op(1, 0, 12'h0AB, g);
        model[0] = EMPTY;
        issue(OP_COLLAPSE, 0, 2, 1'b0);
        wait_done();
        lg_op(0, 0, 0, g);
        lg_op(0, 1, 0, g);

        // Out-of-range collapse row
        issue(OP_COLLAPSE, 25, 1, 1'b1);
        wait_done();
        lg_op(0, 0, 0, g);
        lg_op(0, 3, 0, g);
        lg_op(0, 19, 0, g);

        // NOP encodings
        issue(2'b00, 7, 1, 1'b0);
        wait_done();
        issue(2'b11, 7, 1, 1'b0);
        wait_done();

        // CLEAR_ALL with video every other cycle: row j lands 2j+2 cycles after acceptance
        for (int i = 0; i < ROWS; i++) begin
            old[i]   = model[i];
            model[i] = EMPTY;
        end
        issue(OP_CLEAR_ALL, 0, 2 * ROWS + 1, 1'b0);
        for (int k = 1; k <= 2 * ROWS + 2; k++) begin
            if (k % 2 == 1) begin
                va = 5'((k * 7) % ROWS);
                vid_drive(va, (k >= 2 * va + 3) ? EMPTY : old[va], 1'b0);
            end else begin
                vid_req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        vid_req = 1'b0;
        wait_done();
        for (int i = 0; i < ROWS; i++) lg_op(0, 5'(i), 0, g);

        // Reset in the middle of a collapse
        cmd_valid = 1'b1;
        cmd_op    = OP_COLLAPSE;
        cmd_row   = 5'd15;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("midcmd_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_done", done, 0);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end

        if (q_lg.size() != 0) fail("lg_queue_not_drained");
        if (q_vid.size() != 0) fail("vid_queue_not_drained");
        if (q_done.size() != 0) fail("done_queue_not_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_area_arbiter.md
# game_area_arbiter

Owns the single-port game-area row memory and shares it between the VGA block renderer (read-only, hard real-time), the game logic (read/write request/grant port) and an internal row sequencer that performs whole-field clears and Tetris line-collapse shifts. Sits between game logic and the VGA subsystem; its video port drives `game_area_data` for the `game_area_addr` the renderer issues.

## Interface
Parameters:
- ROWS, 20, number of playfield rows stored (≤ 32)
- COLS, 12, bits per row (10 cells plus 2 wall bits)
- EMPTY_ROW, 12'h801, value written by clears (walls set, cells empty)
- STARVE_MAX, 16, logic-port wait limit in cycles (starvation guard only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- vid_req  in  1  renderer read request this cycle
- vid_addr  in  5  renderer row address
- vid_data  out  COLS  row data, fixed latency
- vid_miss  out  1  pulse: vid_data slot not serviced (repeats previous value)
- lg_req  in  1  logic access request, held until granted
- lg_we  in  1  1 = write, 0 = read
- lg_addr  in  5  logic row address
- lg_wdata  in  COLS  logic write data
- lg_gnt  out  1  access performed this cycle (combinational)
- lg_rvalid  out  1  pulse: lg_rdata valid
- lg_rdata  out  COLS  logic read data
- cmd_valid  in  1  sequencer command strobe
- cmd_op  in  2  01 CLEAR_ALL, 10 COLLAPSE, others NOP
- cmd_row  in  5  row removed by COLLAPSE
- cmd_ready  out  1  high when sequencer IDLE
- busy  out  1  sequencer active
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  pulses with done when cmd_row ≥ ROWS

## Operation
- One RAM access per cycle. Fixed priority: video > sequencer > logic.
- While busy, lg_gnt is forced 0; video keeps reading and may see intermediate rows.
- Command accepted on cmd_valid & cmd_ready. NOP: done next cycle, no access. Commands while busy are ignored.
- Sequencer states: IDLE, CLR, SH_RD, SH_CAP, SH_WR, SH_TOP, DONE.
- CLEAR_ALL: CLR writes EMPTY_ROW to rows 0..ROWS-1 in ascending order, one row per free slot.
- COLLAPSE r: i = r; SH_RD issues read of row i-1; SH_CAP (unconditional, one cycle) latches RAM output into a hold register; SH_WR writes hold to row i; decrement i; repeat while i ≥ 1; SH_TOP writes EMPTY_ROW to row 0; then DONE. r = 0 goes straight to SH_TOP.
- cmd_row ≥ ROWS: no writes, DONE next cycle, cmd_err = 1.
- Any RAM-issuing state stalls, holding its state, when vid_req is high.
- Logic addresses ≥ ROWS are granted but writes are dropped and reads return EMPTY_ROW.
- RAM contents are not reset.

## Timing
- Reset values: vid_data 0, vid_miss 0, lg_gnt 0, lg_rvalid 0, lg_rdata 0, busy 0, done 0, cmd_err 0, state IDLE, cmd_ready 1.
- Read latency is 2 cycles for both ports. An access issued at edge N has data valid after edge N+2 (RAM register plus output register). This holds every cycle for video.
- Uncontested timing: CLEAR_ALL takes ROWS + 1 cycles from acceptance to done; COLLAPSE r takes 3r + 2.
- A write granted at edge N is visible to any read issued at edge N+1 or later.
- Reset mid-command aborts immediately to IDLE. RAM stays partially modified and done does not pulse.

## Configuration
- GAME_AREA_STARVE_GUARD_EN defined: a pending logic request, or sequencer access, that has waited STARVE_MAX consecutive cycles gets one slot over video. The video slot is skipped, vid_data repeats its previous value at the normal latency, and vid_miss pulses aligned with that data. The wait counter resets on each grant.
- Not defined: strict priority, vid_miss tied 0, no wait counter.

## Structure
- game_area_pkg holds ROWS, COLS, EMPTY_ROW and STARVE_MAX defaults, the cmd_op encodings and the sequencer state encoding.
- Sub-module game_area_ram: ROWS × COLS single-port memory, synchronous write, registered read.
- Arbitration, sequencer FSM and output registers live in the top module.

## Test plan
- Logic writes row 5 = 12'hFFF, then reads row 5 -> lg_rvalid 2 cycles after grant, lg_rdata 12'hFFF.
- vid_req held high, lg_req high -> lg_gnt stays 0. Guard build: grant at cycle 16 with one vid_miss pulse. Non-guard build: no grant until vid_req drops.
- Rows 0..19 preloaded with value = row index, COLLAPSE 3, no video -> rows 1..3 = 0,1,2; row 0 = 12'h801; row 4 = 4; done 11 cycles after acceptance.
- CLEAR_ALL with vid_req toggling every cycle -> all rows = 12'h801; done delayed by the stalled cycles; vid_data always matches the 2-cycle-latency model.
- COLLAPSE with cmd_row = 25 -> done and cmd_err next cycle, RAM unchanged.
- rst asserted mid-COLLAPSE -> next cycle busy 0, cmd_ready 1, no done pulse.
